// File: rtl/sr_pkg.sv
// sr_pkg: shared types and default parameter values for the SR latch command
// sequencer (sr_cmd_sequencer) and its input debouncer (sr_debounce).
//   sr_state_t : sequencer FSM states
//   sr_cmd_t   : command recorded when leaving IDLE
package sr_pkg;

   typedef enum logic [1:0] {IDLE, DRIVE, HOLD, CHECK} sr_state_t;
   typedef enum logic       {CMD_SET, CMD_CLR} sr_cmd_t;

   localparam int DEF_DEB_CYCLES    = 4;
   localparam int DEF_PULSE_CYCLES  = 2;
   localparam int DEF_SETTLE_CYCLES = 1;

endpackage

// File: rtl/sr_cmd_sequencer_if.sv
// sr_cmd_sequencer_if: drive/read-back bundle between the sequencer and the
// 1-bit srlatch.
//   S, R, En : latch set, reset and enable drives (sequencer -> latch)
//   q_in     : latch output Q read back (latch -> sequencer)
// master = sequencer side, slave = latch side.
interface sr_cmd_sequencer_if;

   logic S;
   logic R;
   logic En;
   logic q_in;

   modport master (output S, R, En, input q_in);
   modport slave  (input S, R, En, output q_in);

endinterface

// File: rtl/sr_debounce.sv
// sr_debounce: 2-flop synchronizer followed by a counting debouncer for one
// asynchronous request line.
//   clk, rst_n : clock, asynchronous active-low reset
//   din        : raw asynchronous input
//   dout       : debounced, synchronous level (0 after reset)
// dout flips only after the synchronized input has disagreed with it for
// DEB_CYCLES consecutive cycles; any agreement restarts the count.
module sr_debounce
   import sr_pkg::*;
#(
   parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic dout
);

   localparam int CW = $clog2(DEB_CYCLES + 1);
   // Toggling on the DEB_CYCLES-th disagreeing edge: compare against the
   // value the counter holds just before it would reach DEB_CYCLES.
   localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

   logic          sync1;
   logic          sync2;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         cnt   <= '0;
         dout  <= 1'b0;
      end else begin
         sync1 <= din;
         sync2 <= sync1;
         if (sync2 == dout) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            dout <= ~dout;
            cnt  <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/sr_cmd_sequencer.sv
// sr_cmd_sequencer: turns debounced set/clear requests into timed,
// enable-gated S or R pulses for an srlatch and verifies Q afterwards.
//   clk, rst_n       : clock, asynchronous active-low reset
//   set_raw, clr_raw : asynchronous, possibly bouncy request lines
//   lat (master)     : S/R/En drives (registered) and q_in read-back
//   busy             : high whenever the FSM is not in IDLE
//   conflict         : 1-cycle pulse when set and clear are both pending in IDLE
//   err              : 1-cycle pulse (during CHECK) when Q disagrees with the command
module sr_cmd_sequencer
   import sr_pkg::*;
#(
   parameter int DEB_CYCLES    = DEF_DEB_CYCLES,
   parameter int PULSE_CYCLES  = DEF_PULSE_CYCLES,
   parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                set_raw,
   input  logic                clr_raw,
   sr_cmd_sequencer_if.master  lat,
   output logic                busy,
   output logic                conflict,
   output logic                err
);

   localparam int TMAX = (PULSE_CYCLES > SETTLE_CYCLES) ? PULSE_CYCLES : SETTLE_CYCLES;
   localparam int TW   = $clog2(TMAX + 1);
   localparam logic [TW-1:0] PULSE_LAST  = TW'(PULSE_CYCLES - 1);
   localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE_CYCLES - 1);

   logic          set_deb, clr_deb;
   logic          set_deb_d, clr_deb_d;
   logic          set_rise, clr_rise;
   logic          set_pend, clr_pend;
   sr_state_t     state;
   sr_cmd_t       cmd;
   logic [TW-1:0] tmr;

   sr_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_set (
      .clk(clk), .rst_n(rst_n), .din(set_raw), .dout(set_deb));
   sr_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_clr (
      .clk(clk), .rst_n(rst_n), .din(clr_raw), .dout(clr_deb));

   assign set_rise = set_deb & ~set_deb_d;
   assign clr_rise = clr_deb & ~clr_deb_d;
   assign busy     = (state != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         set_deb_d <= 1'b0;
         clr_deb_d <= 1'b0;
         set_pend  <= 1'b0;
         clr_pend  <= 1'b0;
         state     <= IDLE;
         cmd       <= CMD_SET;
         tmr       <= '0;
         lat.S     <= 1'b0;
         lat.R     <= 1'b0;
         lat.En    <= 1'b0;
         conflict  <= 1'b0;
         err       <= 1'b0;
      end else begin
         set_deb_d <= set_deb;
         clr_deb_d <= clr_deb;
         conflict  <= 1'b0;
         err       <= 1'b0;

         case (state)
            IDLE: begin
               tmr <= '0;
               if (set_pend && clr_pend) begin
                  set_pend <= 1'b0;
                  clr_pend <= 1'b0;
                  conflict <= 1'b1;
               end else if (set_pend) begin
                  set_pend <= 1'b0;
                  cmd      <= CMD_SET;
                  lat.En   <= 1'b1;
                  lat.S    <= 1'b1;
                  state    <= DRIVE;
               end else if (clr_pend) begin
                  clr_pend <= 1'b0;
                  cmd      <= CMD_CLR;
                  lat.En   <= 1'b1;
                  lat.R    <= 1'b1;
                  state    <= DRIVE;
               end
            end
            DRIVE: begin
               if (tmr == PULSE_LAST) begin
                  lat.En <= 1'b0;
                  lat.S  <= 1'b0;
                  lat.R  <= 1'b0;
                  tmr    <= '0;
                  state  <= HOLD;
               end else begin
                  tmr <= tmr + 1'b1;
               end
            end
            HOLD: begin
               // Q is sampled on the last settle edge so err is already
               // valid for the single CHECK cycle.
               if (tmr == SETTLE_LAST) begin
                  err   <= (lat.q_in != (cmd == CMD_SET));
                  tmr   <= '0;
                  state <= CHECK;
               end else begin
                  tmr <= tmr + 1'b1;
               end
            end
            CHECK:   state <= IDLE;
            default: state <= IDLE;
         endcase

         // A fresh rise beats a same-cycle consume; a repeat while pending
         // simply merges.
         if (set_rise) set_pend <= 1'b1;
         if (clr_rise) clr_pend <= 1'b1;
      end
   end

endmodule

// File: tb/tb_sr_cmd_sequencer.sv
module tb_sr_cmd_sequencer;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic set_raw = 1'b0;
   logic clr_raw = 1'b0;
   logic force0 = 1'b0;
   logic q_model = 1'b0;
   logic busy, conflict, err;
   logic [5:0] obs;
   logic [5:0] exp_v;
   int errors = 0;
   int checks = 0;

   sr_cmd_sequencer_if lat();

   sr_cmd_sequencer #(.DEB_CYCLES(4), .PULSE_CYCLES(2), .SETTLE_CYCLES(1)) dut (
      .clk(clk), .rst_n(rst_n), .set_raw(set_raw), .clr_raw(clr_raw),
      .lat(lat), .busy(busy), .conflict(conflict), .err(err));

   always #5 clk = ~clk;

   // Behavioural srlatch
   always @(posedge clk) begin
      if (lat.En && lat.S) q_model <= 1'b1;
      else if (lat.En && lat.R) q_model <= 1'b0;
   end
   assign lat.q_in = force0 ? 1'b0 : q_model;

   // Observation vector: {En, S, R, busy, conflict, err}
   assign obs = {lat.En, lat.S, lat.R, busy, conflict, err};

   // Forbidden drive combinations, checked every cycle
   always begin
      @(posedge clk);
      #2;
      checks++;
      if ((lat.S && lat.R) || ((lat.S || lat.R) && !lat.En)) begin
         errors++;
         $display("FAIL forbidden_drive t=%0t S=%b R=%b En=%b expected no S&R and no S/R without En",
                  $time, lat.S, lat.R, lat.En);
      end
   end

   task automatic tick;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      @(negedge clk);
      checks++;
      if (obs !== 6'b000000) begin
         errors++;
         $display("FAIL reset_state obs=%b expected 000000", obs);
      end
      rst_n = 1'b1;
      repeat (4) tick;
      checks++;
      if (obs !== 6'b000000) begin
         errors++;
         $display("FAIL reset_idle obs=%b expected 000000", obs);
      end
   endtask

   task automatic test_clean_set;
      set_raw = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         tick;
         exp_v = {(k == 8 || k == 9), (k == 8 || k == 9), 1'b0, (k >= 8 && k <= 11), 1'b0, 1'b0};
         checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL clean_set edge %0d obs=%b expected %b", k, obs, exp_v);
         end
      end
      set_raw = 1'b0;
      repeat (10) tick;
      checks++;
      if (obs !== 6'b000000) begin
         errors++;
         $display("FAIL set_release obs=%b expected 000000", obs);
      end
   endtask

   task automatic test_glitch;
      set_raw = 1'b1;
      repeat (3) tick;
      set_raw = 1'b0;
      for (int k = 4; k <= 16; k++) begin
         tick;
         checks++;
         if (obs !== 6'b000000) begin
            errors++;
            $display("FAIL glitch edge %0d obs=%b expected 000000", k, obs);
         end
      end
   endtask

   task automatic test_bounce;
      for (int i = 0; i < 10; i++) begin
         clr_raw = (i % 2 == 0);
         tick;
         checks++;
         if (obs !== 6'b000000) begin
            errors++;
            $display("FAIL bounce_toggle cycle %0d obs=%b expected 000000", i, obs);
         end
      end
      clr_raw = 1'b1;
      for (int k = 1; k <= 14; k++) begin
         tick;
         exp_v = {(k == 8 || k == 9), 1'b0, (k == 8 || k == 9), (k >= 8 && k <= 11), 1'b0, 1'b0};
         checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL bounce_settle edge %0d obs=%b expected %b", k, obs, exp_v);
         end
      end
      clr_raw = 1'b0;
      repeat (10) tick;
   endtask

   task automatic test_conflict;
      set_raw = 1'b1;
      clr_raw = 1'b1;
      for (int k = 1; k <= 14; k++) begin
         tick;
         exp_v = {5'b00000, 1'b0};
         exp_v[1] = (k == 8);
         checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL conflict edge %0d obs=%b expected %b", k, obs, exp_v);
         end
      end
      set_raw = 1'b0;
      clr_raw = 1'b0;
      repeat (10) tick;
   endtask

   task automatic test_queued;
      set_raw = 1'b1;
      for (int k = 1; k <= 18; k++) begin
         tick;
         exp_v = {(k == 8 || k == 9 || k == 13 || k == 14), (k == 8 || k == 9),
                  (k == 13 || k == 14), ((k >= 8 && k <= 11) || (k >= 13 && k <= 16)),
                  1'b0, 1'b0};
         checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL queued edge %0d obs=%b expected %b", k, obs, exp_v);
         end
         if (k == 1) clr_raw = 1'b1;
      end
      set_raw = 1'b0;
      clr_raw = 1'b0;
      repeat (10) tick;
   endtask

   task automatic test_mismatch;
      force0  = 1'b1;
      set_raw = 1'b1;
      for (int k = 1; k <= 13; k++) begin
         tick;
         exp_v = {(k == 8 || k == 9), (k == 8 || k == 9), 1'b0, (k >= 8 && k <= 11), 1'b0, (k == 11)};
         checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL mismatch edge %0d obs=%b expected %b", k, obs, exp_v);
         end
      end
      set_raw = 1'b0;
      force0  = 1'b0;
      repeat (10) tick;
   endtask

   task automatic test_mid_reset;
      set_raw = 1'b1;
      repeat (8) tick;
      checks++;
      if (obs !== 6'b110100) begin
         errors++;
         $display("FAIL mid_reset_drive obs=%b expected 110100", obs);
      end
      #1;
      rst_n = 1'b0;
      #1;
      checks++;
      if (obs !== 6'b000000) begin
         errors++;
         $display("FAIL mid_reset_async obs=%b expected 000000", obs);
      end
      set_raw = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 1; k <= 15; k++) begin
         tick;
         checks++;
         if (obs !== 6'b000000) begin
            errors++;
            $display("FAIL no_replay edge %0d obs=%b expected 000000", k, obs);
         end
      end
   endtask

   task automatic test_reset_held_high;
      rst_n   = 1'b0;
      set_raw = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         tick;
         exp_v = {(k == 8 || k == 9), (k == 8 || k == 9), 1'b0, (k >= 8 && k <= 11), 1'b0, 1'b0};
         checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL held_high edge %0d obs=%b expected %b", k, obs, exp_v);
         end
      end
      set_raw = 1'b0;
      repeat (10) tick;
   endtask

   initial begin
      test_reset;
      test_clean_set;
      test_glitch;
      test_bounce;
      test_conflict;
      test_queued;
      test_mismatch;
      test_mid_reset;
      test_reset_held_high;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sr_cmd_sequencer.md
# sr_cmd_sequencer

Upstream command stage for the 1-bit `srlatch`, which has ports `S`, `R`, `En` and `Q`. It takes two raw, asynchronous, bouncy request lines, `set_raw` and `clr_raw`, then synchronizes, debounces and edge-detects them. It converts each accepted request into a timed, enable-gated `S` or `R` pulse and never drives `S` and `R` high together. After every pulse it reads the latch output back on `q_in` and flags a mismatch.

## Interface
Parameters:
- `DEB_CYCLES`, default 4: consecutive stable cycles required to accept an input change; must be at least 1.
- `PULSE_CYCLES`, default 2: number of cycles `En` and `S`/`R` stay high per command; must be at least 1.
- `SETTLE_CYCLES`, default 1: idle cycles after a pulse before `q_in` is checked; must be at least 1.

Ports. One clock; reset is asynchronous and active-low.
- `clk`, input, 1: the single clock.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `set_raw`, input, 1: asynchronous set request.
- `clr_raw`, input, 1: asynchronous clear request.
- `q_in`, input, 1: latch output `Q`, read back.
- `S`, output, 1: latch set drive, registered.
- `R`, output, 1: latch reset drive, registered.
- `En`, output, 1: latch enable, registered.
- `busy`, output, 1: high in every state except IDLE.
- `conflict`, output, 1: one-cycle pulse when set and clear requests collide.
- `err`, output, 1: one-cycle pulse when the read-back mismatches.

## Operation
- **Input conditioning (per channel).** A 2-flop synchronizer feeds a debouncer.
  - Counter width is `$clog2(DEB_CYCLES+1)`.
  - The counter increments while the synchronized value differs from the debounced value, and clears whenever they match.
  - The debounced value toggles when the count reaches `DEB_CYCLES`.
- **Request capture.** A rising edge of a debounced value sets its pending flag, `set_pend` or `clr_pend`.
  - A flag clears when its request is served or discarded.
  - Falling edges are ignored.
- **FSM states.**
  - IDLE → DRIVE when exactly one flag is pending. That flag is consumed and `cmd` records SET or CLR.
  - IDLE with both flags pending: both are discarded, `conflict` pulses for 1 cycle, and the FSM stays in IDLE.
  - DRIVE: `En`=1, plus `S`=1 for SET or `R`=1 for CLR, held for `PULSE_CYCLES` cycles, then → HOLD.
  - HOLD: `En`=`S`=`R`=0 for `SETTLE_CYCLES` cycles, then → CHECK.
  - CHECK: one cycle. Expected `q_in` is 1 for SET and 0 for CLR. On mismatch `err` pulses. Then → IDLE.
- **Requests arriving while busy.** They set their flags and wait for IDLE.
  - If the opposite flag becomes pending as well, the conflict rule applies at IDLE.
  - A repeat of the same request while its flag is already set is merged into it.
- **Forbidden combinations.**
  - `S`=`R`=1 never occurs.
  - `S` or `R` never asserts without `En`.
- **Reset.** Assertion of `rst_n` clears immediately (asynchronously), mid-operation or not:
  - synchronizers, debounced values, counters, flags and FSM (to IDLE);
  - all outputs to 0.
- **After reset.** Inputs held high at reset release produce a request after the normal conditioning delay, because the debounced values start at 0.

## Timing
- **Request latency.** From the first clock edge that samples `set_raw`=1 and keeps it stable, `En` and `S` are high at edge `DEB_CYCLES`+4: 2 synchronizer edges, `DEB_CYCLES` debounce edges, 1 pend edge, 1 FSM edge. With defaults, that is edge 8.
- **Command duration.** `busy` spans `PULSE_CYCLES`+`SETTLE_CYCLES`+1 cycles per command, which is 4 with defaults.
- **Back-to-back commands.** Minimum spacing is one IDLE cycle.
- **Pulse timing.** `err` and `conflict` are high for exactly one cycle, registered.
- **Glitch rejection.** A glitch shorter than `DEB_CYCLES` synchronized cycles produces no output.

## Structure
- **Shared package `sr_pkg`.**
  - Enum `sr_state_t` {IDLE, DRIVE, HOLD, CHECK}.
  - Enum `sr_cmd_t` {CMD_SET, CMD_CLR}.
  - Default parameter constants.
- **Sub-module `sr_debounce`.** Contains the synchronizer, counter and debounced register, parameterised by `DEB_CYCLES`. It is instantiated twice.
- **Top level.** Holds edge detect, pending flags, FSM and output registers.

## Test plan
- **Clean set.** `set_raw` goes high and stays high → `S`=`En`=1 at edge 8 for 2 cycles. With `q_in` tied to the latch model at 1, `err`=0.
- **Bounce rejection.** `clr_raw` toggles every cycle for 10 cycles, then settles high → exactly one `R` pulse, emitted 8 edges after settling.
- **Simultaneous requests.** `set_raw` and `clr_raw` rise on the same edge → `conflict` pulses once, and `S`/`R`/`En` stay 0.
- **Queued request.** A set is in DRIVE when a clear rise arrives → the `R` pulse follows immediately after the current CHECK plus one IDLE cycle. `S` and `R` are never high together.
- **Mismatch.** Set command with `q_in` forced to 0 → `err`=1 for exactly one cycle in CHECK.
- **Mid-pulse reset.** `rst_n` is pulled low during DRIVE → `S`/`R`/`En`/`busy` drop to 0 without waiting for a clock edge. No command replays after release unless the inputs re-qualify.
